// File: rtl/ysyx_25060173_alu_arbiter.sv
// ysyx_25060173_alu_arbiter: shares one combinational RV32 ALU between two requesters
//   clk, rst_n                    : clock, synchronous active-low reset
//   req{0,1}_valid/_ready         : request handshake (ready = grant, combinational)
//   req{0,1}_src1/_src2/_op       : operands and one-hot ALU op
//   rsp{0,1}_valid/_ready         : one-deep registered response slot handshake
//   rsp{0,1}_result/_err          : captured ALU result, op-not-one-hot flag
//   alu_src1/_src2/_op, alu_result: connection to the shared ALU
module ysyx_25060173_alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 11,
    parameter int RR_EN  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_src1,
    input  logic [DATA_W-1:0] req0_src2,
    input  logic [OP_W-1:0]   req0_op,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_result,
    output logic              rsp0_err,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_src1,
    input  logic [DATA_W-1:0] req1_src2,
    input  logic [OP_W-1:0]   req1_op,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_result,
    output logic              rsp1_err,
    output logic [DATA_W-1:0] alu_src1,
    output logic [DATA_W-1:0] alu_src2,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_result
);
    logic prio;
    logic elig0, elig1, grant0, grant1;
    // A slot may be drained and refilled in the same cycle
    always_comb begin
        elig0    = req0_valid & (~rsp0_valid | rsp0_ready);
        elig1    = req1_valid & (~rsp1_valid | rsp1_ready);
        grant0   = elig0 & (~elig1 | ~prio);
        grant1   = elig1 & (~elig0 | prio);
        alu_src1 = grant0 ? req0_src1 : grant1 ? req1_src1 : '0;
        alu_src2 = grant0 ? req0_src2 : grant1 ? req1_src2 : '0;
        alu_op   = grant0 ? req0_op : grant1 ? req1_op : '0;
    end
    assign req0_ready = grant0;
    assign req1_ready = grant1;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp0_valid  <= 1'b0;
            rsp0_result <= '0;
            rsp0_err    <= 1'b0;
            rsp1_valid  <= 1'b0;
            rsp1_result <= '0;
            rsp1_err    <= 1'b0;
            prio        <= 1'b0;
        end else begin
            if (grant0) begin
                rsp0_valid  <= 1'b1;
                rsp0_result <= alu_result;
                rsp0_err    <= $countones(req0_op) != 1;
            end else if (rsp0_ready) begin
                rsp0_valid <= 1'b0;
            end
            if (grant1) begin
                rsp1_valid  <= 1'b1;
                rsp1_result <= alu_result;
                rsp1_err    <= $countones(req1_op) != 1;
            end else if (rsp1_ready) begin
                rsp1_valid <= 1'b0;
            end
            // Round-robin hands priority to whichever requester did not win
            if (grant0 | grant1) prio <= (RR_EN != 0) ? grant0 : 1'b0;
        end
    end
endmodule

// File: tb/tb_ysyx_25060173_alu_arbiter.sv
// tb_ysyx_25060173_alu_arbiter: round-robin and fixed-priority arbiters checked against a slot-level model
module tb_ysyx_25060173_alu_arbiter;
    localparam int W  = 32;
    localparam int OW = 11;
    logic          clk = 1'b0;
    logic          rst_n;
    logic          v [2];
    logic [W-1:0]  s1 [2];
    logic [W-1:0]  s2 [2];
    logic [OW-1:0] op [2];
    logic          rr [2];
    logic          qr [2][2];
    logic          rv [2][2];
    logic          re [2][2];
    logic [W-1:0]  res [2][2];
    logic [W-1:0]  as1 [2];
    logic [W-1:0]  as2 [2];
    logic [W-1:0]  ares [2];
    logic [OW-1:0] aop [2];
    logic          mv [2][2];
    logic [W-1:0]  mr [2][2];
    logic          me [2][2];
    int            mp [2];
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    function automatic logic [W-1:0] alu(input logic [W-1:0] a, input logic [W-1:0] b, input logic [OW-1:0] o);
        if (o[0]) return a - b;
        if (o[1]) return {31'b0, $signed(a) < $signed(b)};
        if (o[2]) return a + b;
        if (o[3]) return a ^ b;
        if (o[4]) return a & b;
        if (o[5]) return a | b;
        if (o[6]) return a << b[4:0];
        if (o[7]) return a >> b[4:0];
        if (o[8]) return W'($signed(a) >>> b[4:0]);
        if (o[9]) return {31'b0, a < b};
        if (o[10]) return b;
        return a + b;
    endfunction

    for (genvar d = 0; d < 2; d++) begin : g_dut
        ysyx_25060173_alu_arbiter #(.DATA_W(W), .OP_W(OW), .RR_EN(d == 0 ? 1 : 0)) dut (
            .clk(clk), .rst_n(rst_n),
            .req0_valid(v[0]), .req0_ready(qr[d][0]), .req0_src1(s1[0]), .req0_src2(s2[0]), .req0_op(op[0]),
            .rsp0_valid(rv[d][0]), .rsp0_ready(rr[0]), .rsp0_result(res[d][0]), .rsp0_err(re[d][0]),
            .req1_valid(v[1]), .req1_ready(qr[d][1]), .req1_src1(s1[1]), .req1_src2(s2[1]), .req1_op(op[1]),
            .rsp1_valid(rv[d][1]), .rsp1_ready(rr[1]), .rsp1_result(res[d][1]), .rsp1_err(re[d][1]),
            .alu_src1(as1[d]), .alu_src2(as2[d]), .alu_op(aop[d]), .alu_result(ares[d])
        );
        assign ares[d] = alu(as1[d], as2[d], aop[d]);
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_slots();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("rsp_valid d%0d r%0d", d, i), W'(rv[d][i]), W'(mv[d][i]));
                chk($sformatf("rsp_result d%0d r%0d", d, i), res[d][i], mr[d][i]);
                chk($sformatf("rsp_err d%0d r%0d", d, i), W'(re[d][i]), W'(me[d][i]));
            end
    endtask

    // One clock: check grants and ALU drive, advance the model across the edge, check slots
    task automatic step();
        bit el [2];
        bit gr [2][2];
        int w;
        #1;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 2; i++) el[i] = v[i] && (!mv[d][i] || rr[i]);
            w = -1;
            if (el[0] && el[1]) w = mp[d];
            else if (el[0]) w = 0;
            else if (el[1]) w = 1;
            for (int i = 0; i < 2; i++) begin
                gr[d][i] = (w == i);
                chk($sformatf("req_ready d%0d r%0d", d, i), W'(qr[d][i]), W'(gr[d][i]));
            end
            chk($sformatf("alu_src1 d%0d", d), as1[d], w < 0 ? '0 : s1[w]);
            chk($sformatf("alu_src2 d%0d", d), as2[d], w < 0 ? '0 : s2[w]);
            chk($sformatf("alu_op d%0d", d), W'(aop[d]), w < 0 ? '0 : W'(op[w]));
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                mp[d] = 0;
                for (int i = 0; i < 2; i++) begin
                    mv[d][i] = 0;
                    mr[d][i] = '0;
                    me[d][i] = 0;
                end
            end else begin
                for (int i = 0; i < 2; i++) begin
                    if (gr[d][i]) begin
                        mv[d][i] = 1;
                        mr[d][i] = alu(s1[i], s2[i], op[i]);
                        me[d][i] = $countones(op[i]) != 1;
                    end else if (rr[i]) begin
                        mv[d][i] = 0;
                    end
                end
                if (d == 0 && gr[d][0]) mp[d] = 1;
                if (d == 0 && gr[d][1]) mp[d] = 0;
            end
        end
        #1;
        chk_slots();
    endtask

    task automatic set(input int i, input logic vv, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [OW-1:0] o, input logic r);
        v[i] = vv; s1[i] = a; s2[i] = b; op[i] = o; rr[i] = r;
    endtask

    initial begin
        rst_n = 1'b0;
        set(0, 0, 0, 0, 0, 1);
        set(1, 0, 0, 0, 0, 1);
        for (int d = 0; d < 2; d++) begin
            mp[d] = 0;
            for (int i = 0; i < 2; i++) begin
                mv[d][i] = 0; mr[d][i] = '0; me[d][i] = 0;
            end
        end
        repeat (2) @(posedge clk);
        #1;
        chk_slots();
        rst_n = 1'b1;
        set(0, 1, 5, 3, 11'h004, 1);
        step();
        chk("add result", res[0][0], 8);
        chk("add err", W'(re[0][0]), 0);
        set(0, 0, 0, 0, 0, 1);
        step();
        chk("add drained", W'(rv[0][0]), 0);
        set(1, 1, 3, 5, 11'h200, 1);
        step();
        chk("bltu taken", res[0][1], 1);
        set(1, 1, 5, 3, 11'h200, 1);
        step();
        chk("bltu not taken", res[0][1], 0);
        set(0, 1, 1, 2, 11'h004, 1);
        set(1, 1, 32'hF0, 32'h3C, 11'h010, 1);
        step();
        chk("contend rsp0", res[0][0], 3);
        step();
        chk("contend rsp1", res[0][1], 32'h30);
        repeat (4) step();
        set(0, 1, 7, 9, 11'h004, 0);
        step();
        set(0, 1, 100, 200, 11'h004, 0);
        repeat (3) begin
            set(1, 1, $urandom, $urandom, 11'h008, 1);
            step();
            chk("held result", res[0][0], 16);
        end
        rr[0] = 1;
        step();
        chk("release result", res[0][0], 300);
        set(1, 0, 0, 0, 0, 1);
        set(0, 1, $urandom, $urandom, 11'h003, 1);
        step();
        chk("illegal err", W'(re[0][0]), 1);
        set(0, 1, 2, 2, 11'h000, 1);
        step();
        chk("zero op result", res[0][0], 4);
        chk("zero op err", W'(re[0][0]), 1);
        set(0, 1, 1, 1, 11'h004, 0);
        step();
        rst_n = 1'b0;
        step();
        chk("reset drops rsp", W'(rv[0][0]), 0);
        rst_n = 1'b1;
        set(0, 1, 4, 4, 11'h004, 1);
        set(1, 1, 6, 6, 11'h004, 1);
        repeat (6) begin
            step();
            chk("fixed never grants 1", W'(rv[1][1]), 0);
        end
        for (int n = 0; n < 400; n++) begin
            rst_n = ($urandom_range(59, 0) != 0);
            for (int i = 0; i < 2; i++)
                set(i, $urandom_range(3, 0) != 0, $urandom, $urandom,
                    $urandom_range(4, 0) != 0 ? OW'(11'd1 << $urandom_range(10, 0)) : OW'($urandom),
                    $urandom_range(2, 0) != 0);
            step();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ysyx_25060173_alu_arbiter.md
Name: ysyx_25060173_alu_arbiter

Overview:
- Shares the single combinational RV32 ALU between two requesters: req0 is the execute stage and req1 is the branch/address unit.
- Each cycle it grants at most one request, drives the ALU operands and one-hot op from the winner, and captures the ALU result into that requester's response slot.
- Handshakes are valid/ready on both the request and response sides.
- Arbitration is round-robin by default, with a fixed-priority option.

Parameters:
DATA_W, 32, operand/result width (ALU fixed at 32; other values unsupported)
OP_W, 11, one-hot ALU op width (matches ALU alu_op)
RR_EN, 1, 1 = round-robin between requesters; 0 = fixed priority, req0 always wins

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 accepted this cycle
req0_src1  in  DATA_W  operand 1
req0_src2  in  DATA_W  operand 2
req0_op  in  OP_W  one-hot ALU op
rsp0_valid  out  1  result available for requester 0
rsp0_ready  in  1  requester 0 consumes result
rsp0_result  out  DATA_W  registered ALU result
rsp0_err  out  1  op was not exactly one-hot
req1_valid, req1_ready, req1_src1, req1_src2, req1_op, rsp1_valid, rsp1_ready, rsp1_result, rsp1_err: same as the port-0 set, for requester 1
alu_src1  out  DATA_W  to ALU alu_src1
alu_src2  out  DATA_W  to ALU alu_src2
alu_op  out  OP_W  to ALU alu_op
alu_result  in  DATA_W  from ALU alu_result

Behaviour:
- Reset (rst_n=0 at a clock edge): rsp*_valid=0, rsp*_result=0, rsp*_err=0, prio=0. Any pending responses are dropped; nothing is replayed.
- Slot state per requester i: rsp_i_valid, rsp_i_result, rsp_i_err.
- Slot free: free_i = ~rsp_i_valid | rsp_i_ready. A drain and a refill are allowed in the same cycle.
- Eligible: elig_i = req_i_valid & free_i.
- Winner:
  - Only one requester eligible: it wins.
  - Both eligible: the requester indexed by prio wins.
  - Neither eligible: no grant.
- Handshake timing:
  - req_i_ready = grant_i, combinational; it may depend on req_i_valid.
  - req fields are sampled only when grant_i=1. A requester must hold its fields stable while valid and not ready.
- ALU drive (combinational):
  - alu_src1, alu_src2, alu_op = winner's fields.
  - With no grant, all three are driven to 0.
- On a clock edge with grant_i:
  - rsp_i_valid <= 1
  - rsp_i_result <= alu_result
  - rsp_i_err <= (popcount(req_i_op) != 1)
- Latency: accept in cycle N, response valid in cycle N+1. Aggregate throughput is 1 op/cycle; per requester it is 1 op/cycle while rsp_i_ready stays high.
- No grant to i, and rsp_i_valid & rsp_i_ready: rsp_i_valid <= 0. Result and err hold their last value.
- Held response: while rsp_i_valid=1 and rsp_i_ready=0, rsp_i_result and rsp_i_err are stable, and req_i_ready=0.
- Priority update:
  - RR_EN=1: on any grant, prio <= index of the non-winner. A lone requester therefore never loses a slot, and under contention the requesters alternate.
  - RR_EN=0: prio stays 0.
- Illegal op:
  - The op is still forwarded unmodified; the ALU's own priority decides the result, and rsp_i_err flags it.
  - An all-zero op yields src1+src2 with err=1.
- Each requester has at most one result in flight; there is no queue beyond its one slot.

Test Plan:
- Reset, then req0 add (op=0x004), src1=5, src2=3, rsp0_ready=1 -> req0_ready=1 in cycle 0; cycle 1: rsp0_valid=1, rsp0_result=8, rsp0_err=0; cycle 2: rsp0_valid=0.
- req1 bltu (op=0x200), src1=3, src2=5 -> rsp1_result=1. Repeat with src1=5, src2=3 -> rsp1_result=0.
- Contention (RR_EN=1, both valid from cycle 0):
  - req0 add 1,2; req1 and (op=0x010) 0xF0,0x3C.
  - Cycle 0: grant req0. Cycle 1: rsp0=3, grant req1. Cycle 2: rsp1=0x30.
  - Then both stay valid -> grants alternate 0,1,0,1.
- Backpressure:
  - rsp0_valid=1, rsp0_ready=0, new req0_valid=1 -> req0_ready=0 and rsp0_result holds; req1 is still granted every cycle.
  - Raise rsp0_ready -> req0 is granted in the same cycle.
- Illegal op: req0_op=0x003 -> rsp0_err=1. req0_op=0x000, src 2,2 -> rsp0_result=4, rsp0_err=1.
- Reset and fixed priority:
  - Assert rst_n=0 while rsp0_valid=1 -> next cycle rsp0_valid=0, prio=0.
  - RR_EN=0 with both valid continuously -> req1 is never granted while req0 stays eligible.
